adc_spi_responder: RTL

Serial-side model of the 8-channel 12-bit SPI ADC on the DE0-Nano board, acting as the responder to the board's ADC controller. It oversamples CS_n/SCLK/DIN on the system clock, captures the 3-bit channel address, and shifts a 12-bit sample from a writable 8-entry sample bank onto DOUT in the device's 16-clock frame format. It is used for loopback tests and for FPGA builds without the ADC populated.

---
 rtl/adc_spi_responder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/adc_spi_responder.sv
// -----------------------------------------------------------------------------
// adc_spi_responder
//
// Serial-side model of the DE0-Nano 8-channel 12-bit SPI ADC. It plays the
// responder role towards the board's ADC controller. CS_n, SCLK and DIN are
// oversampled on iCLK. A 3-bit channel address is captured from DIN on rising
// SCLK counts 3..5. A 12-bit sample from a writable 8-entry bank is shifted out
// on DOUT in a 16-SCLK frame: four zeros, then D11..D0.
//
// Ports
//   iRST         async active-low reset
//   iCLK         system clock (>= 8x SCLK)
//   iCS_n        SPI chip select, active-low (asynchronous)
//   iSCLK        SPI clock, idles high (asynchronous)
//   iDIN         SPI data from controller, taken on rising SCLK
//   oDOUT        SPI data to controller, updated after falling SCLK
//   oDOUT_OE     high while the responder owns the DOUT pad
//   iWR          sample-bank write strobe (one iCLK cycle)
//   iWR_CH       bank entry to write
//   iWR_DATA     sample value to write
//   oFRAME_DONE  one-cycle pulse on the 16th rising SCLK of a frame
//   oFRAME_CH    channel carried by the last completed frame
//   oNEXT_CH     channel the next frame will carry
//   oFRAMES      completed-frame counter (wraps)
// -----------------------------------------------------------------------------
module adc_spi_responder (
   input  logic        iRST,
   input  logic        iCLK,
   input  logic        iCS_n,
   input  logic        iSCLK,
   input  logic        iDIN,
   output logic        oDOUT,
   output logic        oDOUT_OE,
   input  logic        iWR,
   input  logic [2:0]  iWR_CH,
   input  logic [11:0] iWR_DATA,
   output logic        oFRAME_DONE,
   output logic [2:0]  oFRAME_CH,
   output logic [2:0]  oNEXT_CH,
   output logic [15:0] oFRAMES
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // Synchronizers: bit 0 = first flop, bit 1 = synchronized value,
   // bit 2 = previous synchronized value (edge detection).
   logic [2:0]  cs_sync_q;
   logic [2:0]  sclk_sync_q;
   logic [1:0]  din_sync_q;

   logic [11:0] bank_q [8];

   state_t      state_q;
   logic [15:0] shift_q;
   logic [4:0]  cnt_q;
   logic [2:1]  addr_q;
   logic [2:0]  cur_ch_q;
   logic [2:0]  next_ch_q;
   logic [2:0]  frame_ch_q;
   logic [15:0] frames_q;
   logic        frame_done_q;
   logic        dout_q;

   logic        cs_fall;
   logic        cs_rise;
   logic        sclk_rise;
   logic        sclk_fall;
   logic        din_s;
   logic [4:0]  cnt_d;
   logic [15:0] snap_d;

   // CS synchronizer resets to "low" so that a CS already held low when reset
   // is released is not mistaken for a fresh CS fall; the block then stays
   // idle until a genuine falling edge is seen. A spurious "rise" out of
   // reset is harmless because it only re-asserts the idle state.
   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         cs_sync_q   <= 3'b000;
         sclk_sync_q <= 3'b111;
         din_sync_q  <= 2'b00;
      end else begin
         cs_sync_q   <= {cs_sync_q[1:0], iCS_n};
         sclk_sync_q <= {sclk_sync_q[1:0], iSCLK};
         din_sync_q  <= {din_sync_q[0], iDIN};
      end
   end

   assign cs_fall   =  cs_sync_q[2]   & ~cs_sync_q[1];
   assign cs_rise   = ~cs_sync_q[2]   &  cs_sync_q[1];
   assign sclk_rise = ~sclk_sync_q[2] &  sclk_sync_q[1];
   assign sclk_fall =  sclk_sync_q[2] & ~sclk_sync_q[1];
   assign din_s     =  din_sync_q[1];

   // Sample bank. A write in the same cycle as a frame-start snapshot lands
   // after the snapshot has read the old value (both are registered).
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_bank
         always_ff @(posedge iCLK or negedge iRST) begin
            if (!iRST) begin
               bank_q[gi] <= 12'h000;
            end else if (iWR && (iWR_CH == 3'(gi))) begin
               bank_q[gi] <= iWR_DATA;
            end
         end
      end
   endgenerate

   assign cnt_d  = cnt_q + 5'd1;
   assign snap_d = {4'b0000, bank_q[next_ch_q]};

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state_q      <= ST_IDLE;
         shift_q      <= 16'h0000;
         cnt_q        <= 5'd0;
         addr_q       <= 2'b00;
         cur_ch_q     <= 3'd0;
         next_ch_q    <= 3'd0;
         frame_ch_q   <= 3'd0;
         frames_q     <= 16'h0000;
         frame_done_q <= 1'b0;
         dout_q       <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cs_fall) begin
                  state_q  <= ST_ACTIVE;
                  cur_ch_q <= next_ch_q;
                  shift_q  <= snap_d;
                  cnt_q    <= 5'd0;
                  dout_q   <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  // Abort or normal end: partial address bits are simply
                  // never used because the next frame re-captures all three.
                  state_q <= ST_IDLE;
                  cnt_q   <= 5'd0;
                  dout_q  <= 1'b0;
               end else if (sclk_rise) begin
                  if (cnt_d == 5'd16) begin
                     // Frame complete; with CS still low the next frame
                     // starts immediately (back-to-back).
                     frame_done_q <= 1'b1;
                     frame_ch_q   <= cur_ch_q;
                     frames_q     <= frames_q + 16'd1;
                     cur_ch_q     <= next_ch_q;
                     shift_q      <= snap_d;
                     cnt_q        <= 5'd0;
                     dout_q       <= 1'b0;
                  end else begin
                     cnt_q <= cnt_d;
                     if (cnt_d == 5'd3) addr_q[2] <= din_s;
                     if (cnt_d == 5'd4) addr_q[1] <= din_s;
                     if (cnt_d == 5'd5) next_ch_q <= {addr_q, din_s};
                  end
               end else if (sclk_fall && (cnt_q != 5'd0) && (cnt_q != 5'd16)) begin
                  shift_q <= {shift_q[14:0], 1'b0};
                  dout_q  <= shift_q[14];
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign oDOUT       = dout_q;
   assign oDOUT_OE    = (state_q == ST_ACTIVE);
   assign oFRAME_DONE = frame_done_q;
   assign oFRAME_CH   = frame_ch_q;
   assign oNEXT_CH    = next_ch_q;
   assign oFRAMES     = frames_q;

endmodule
